// File: rtl/instr_fetch_unit_pkg.sv
// Shared defaults and state encoding for the instruction fetch unit.
// Imported by the fetch top and its skid buffer.
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W   = 7;
  localparam int IFU_DATA_W   = 16;
  localparam int IFU_RESET_PC = 0;

  // Cycles between a RAM read request and its data appearing on dout.
  localparam int RAM_RD_LATENCY = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_skid_buf.sv
// One-entry data+pc holding buffer for a RAM word that returns while the
// output register is occupied and not being consumed.
module fetch_skid_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] din_pc,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_pc
);

  // A load in the same cycle as a pop replaces the entry, so it stays full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      dout    <= '0;
      dout_pc <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full    <= 1'b1;
      dout    <= din;
      dout_pc <= din_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and fetch stage in front of the 16x128 program RAM.
// Delivers one instruction per cycle to decode, with branch redirect and flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  // Handshake: a word transfers in any cycle where instr_valid && instr_ready;
  // while instr_valid && !instr_ready, instr and instr_pc are held unchanged.

  fetch_state_t                state;
  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           inflight_pc;
  logic [RAM_RD_LATENCY-1:0]   inflight;

  logic                        skid_full;
  logic [DATA_W-1:0]           skid_data;
  logic [ADDR_W-1:0]           skid_pc;

  logic issue, consume, out_free, capture, capture_to_out, skid_load, skid_pop;

  assign consume  = instr_valid && instr_ready;
  assign out_free = !instr_valid || consume;
  assign issue    = (state == RUN) && run && !branch_valid
                    && !(instr_valid && !instr_ready) && !skid_full;

  // The returning word is dropped outright when a branch lands on it.
  assign capture        = inflight[0] && !branch_valid;
  assign capture_to_out = capture && out_free && !skid_full;
  assign skid_load      = capture && !capture_to_out;
  assign skid_pop       = out_free && skid_full && !branch_valid;

  assign mem_read_en = issue;
  assign mem_addr    = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= '0;
      inflight_pc <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        IDLE: if (run) state <= RUN;
        RUN:  if (!run && !inflight[0] && !skid_full) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (branch_valid) begin
        pc          <= branch_target;
        inflight    <= '0;
        instr_valid <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc          <= pc + ADDR_W'(1);
          inflight_pc <= pc;
        end
        if (skid_pop) begin
          instr       <= skid_data;
          instr_pc    <= skid_pc;
          instr_valid <= 1'b1;
        end else if (capture_to_out) begin
          instr       <= mem_dout;
          instr_pc    <= inflight_pc;
          instr_valid <= 1'b1;
        end else if (consume) begin
          instr_valid <= 1'b0;
        end
      end
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_valid),
    .load    (skid_load),
    .din     (mem_dout),
    .din_pc  (inflight_pc),
    .pop     (skid_pop),
    .full    (skid_full),
    .dout    (skid_data),
    .dout_pc (skid_pc)
  );

endmodule
